ahb_gpio: RTL and testbench
===========================

# ahb_gpio

Parametrised AHB-Lite GPIO slave and the successor to the fixed 4-bit LED PIO on the SOPC slave-1 port. It provides WIDTH bidirectional pins with per-pin direction, atomic set/clear of outputs, a configurable input synchronizer, and per-pin edge/level interrupts merged into one IRQ line for the CPU. Zero-wait-state, always OKAY.

## Interface
- WIDTH, 8: number of GPIO pins, 1..32; register bits above WIDTH-1 read 0, writes ignored.
- SYNC_STAGES, 2: input synchronizer depth, 2..3.
- RESET_OUT, 0: reset value of DATA_OUT[WIDTH-1:0].
- HCLK  in  1  single clock; all state on rising edge.
- HRESETn  in  1  asynchronous, active-low reset.
- HSEL  in  1  slave select from interconnect.
- HADDR  in  32  address; only HADDR[5:0] decoded.
- HTRANS  in  2  transfer type; NONSEQ/SEQ (HTRANS[1]=1) are valid.
- HSIZE  in  3  byte/half/word.
- HPROT  in  4  ignored.
- HWRITE  in  1  1 = write.
- HREADY  in  1  bus-wide ready.
- HWDATA  in  32  write data (data phase).
- HREADYOUT  out  1  constant 1.
- HRDATA  out  32  read data (data phase).
- HRESP  out  1  constant 0 (OKAY).
- GPIO_IN  in  WIDTH  asynchronous pad inputs.
- GPIO_OUT  out  WIDTH  DATA_OUT register.
- GPIO_OE  out  WIDTH  DIR register, 1 = drive.
- IRQ  out  1  registered |(INT_STATUS & INT_EN).

## Operation
- Address phase accepted when HSEL & HREADY & HTRANS[1]; register addr[5:2], HWRITE, byte strobes (from HSIZE, HADDR[1:0]); else data-phase valid flag cleared.
- Writes commit at the rising edge ending the data phase, per byte strobe. Reads: HRDATA = combinational mux of registered offset during a valid read data phase, else 0. Back-to-back write then read of same register returns new value.
- Register map (byte offsets): 0x00 DATA_IN RO (synchronized pins); 0x04 DATA_OUT RW; 0x08 OUT_SET WO (1 sets DATA_OUT bit, reads 0); 0x0C OUT_CLR WO (1 clears, reads 0); 0x10 DIR RW; 0x14 INT_EN RW; 0x18 INT_TYPE RW (1 edge, 0 level); 0x1C INT_POL RW (1 rising/high, 0 falling/low); 0x20 INT_STATUS (edge bits W1C, level bits RO live). Offsets 0x24..0x3C read 0, writes ignored, OKAY.
- Input path: SYNC_STAGES flops then one "prev" flop; rise = sync & ~prev, fall = ~sync & prev.
- Edge bit i: set when INT_TYPE[i] & (INT_POL[i] ? rise : fall); set independent of INT_EN; cleared by writing 1. Set and W1C same cycle: set wins.
- Level bit i: INT_STATUS[i] = ~INT_TYPE[i] & (sync[i] == INT_POL[i]); write ignored.
- Changing INT_TYPE from edge to level discards stored edge status.

## Timing
- Reset (async assert, sync use of deassert via upstream rst_sync): DATA_OUT=RESET_OUT, DIR/INT_EN/INT_TYPE/INT_POL/edge status=0, sync and prev flops=0, data-phase flag=0, IRQ=0, HRDATA=0, HREADYOUT=1, HRESP=0.
- Reset mid-transfer: pending write dropped; no partial commit.
- GPIO_OUT/GPIO_OE change one cycle after write data phase (at its closing edge).
- Pin transition first sampled at edge k: DATA_IN readable from edge k+SYNC_STAGES-1; edge status set at edge k+SYNC_STAGES; IRQ high after edge k+SYNC_STAGES+1.
- W1C of last pending bit: IRQ low one edge after the write commits.
- Pulses shorter than one HCLK period may be missed; no requirement.

## Test plan
- Reset with RESET_OUT=8'hA5: GPIO_OUT=8'hA5, GPIO_OE=0, IRQ=0, read 0x10 -> 0, read 0x3C -> 0, HRESP=0 throughout.
- Write DATA_OUT=8'h0F, OUT_SET=8'hF0, OUT_CLR=8'h03 back-to-back, then read 0x04 -> 8'hFC; byte write 8'h55 to 0x05 with WIDTH=16 leaves low byte intact.
- INT_TYPE[2]=1, INT_POL[2]=1, INT_EN[2]=1; raise GPIO_IN[2] -> IRQ high SYNC_STAGES+2 edges later, read 0x20 -> 0x4; write 0x4 to 0x20 -> IRQ low next edge.
- Level-low on pin 0: drive GPIO_IN[0]=0 -> IRQ asserted; W1C has no effect; drive 1 -> status and IRQ clear after sync latency.
- Rising edge arrives in same cycle as W1C of that bit -> status remains 1, IRQ stays high.
- Assert HRESETn low during write data phase to 0x04 -> GPIO_OUT returns to RESET_OUT, write not applied.

Source files
------------

// File: rtl/ahb_gpio.sv
// ahb_gpio: AHB-Lite GPIO slave with WIDTH bidirectional pins.
//   Zero-wait-state, always OKAY. Per-pin direction, atomic set/clear of
//   the output register, a SYNC_STAGES-deep input synchronizer and per-pin
//   edge/level interrupts merged into a single registered IRQ.
// Ports:
//   HCLK, HRESETn            clock, asynchronous active-low reset
//   HSEL, HADDR, HTRANS,
//   HSIZE, HPROT, HWRITE,
//   HREADY, HWDATA           AHB-Lite slave inputs (HPROT ignored)
//   HREADYOUT, HRDATA, HRESP AHB-Lite slave outputs
//   GPIO_IN                  asynchronous pad inputs
//   GPIO_OUT, GPIO_OE        output data and output enable (1 = drive)
//   IRQ                      registered OR of enabled pending interrupts
// Register map (byte offsets): 0x00 DATA_IN, 0x04 DATA_OUT, 0x08 OUT_SET,
//   0x0C OUT_CLR, 0x10 DIR, 0x14 INT_EN, 0x18 INT_TYPE, 0x1C INT_POL,
//   0x20 INT_STATUS. Everything else reads 0 and ignores writes.
module ahb_gpio #(
  parameter int                WIDTH       = 8,
  parameter int                SYNC_STAGES = 2,
  parameter logic [WIDTH-1:0]  RESET_OUT   = '0
) (
  input  logic             HCLK,
  input  logic             HRESETn,
  input  logic             HSEL,
  input  logic [31:0]      HADDR,
  input  logic [1:0]       HTRANS,
  input  logic [2:0]       HSIZE,
  input  logic [3:0]       HPROT,
  input  logic             HWRITE,
  input  logic             HREADY,
  input  logic [31:0]      HWDATA,
  output logic             HREADYOUT,
  output logic [31:0]      HRDATA,
  output logic             HRESP,
  input  logic [WIDTH-1:0] GPIO_IN,
  output logic [WIDTH-1:0] GPIO_OUT,
  output logic [WIDTH-1:0] GPIO_OE,
  output logic             IRQ
);

  localparam logic [3:0] OFF_DATA_IN    = 4'h0;
  localparam logic [3:0] OFF_DATA_OUT   = 4'h1;
  localparam logic [3:0] OFF_OUT_SET    = 4'h2;
  localparam logic [3:0] OFF_OUT_CLR    = 4'h3;
  localparam logic [3:0] OFF_DIR        = 4'h4;
  localparam logic [3:0] OFF_INT_EN     = 4'h5;
  localparam logic [3:0] OFF_INT_TYPE   = 4'h6;
  localparam logic [3:0] OFF_INT_POL    = 4'h7;
  localparam logic [3:0] OFF_INT_STATUS = 4'h8;

  // Byte lanes touched by a transfer of the given size at the given lane.
  function automatic logic [3:0] byte_strobes(input logic [2:0] size,
                                              input logic [1:0] lane);
    logic [3:0] s;
    case (size)
      3'd0:    s = 4'b0001 << lane;
      3'd1:    s = lane[1] ? 4'b1100 : 4'b0011;
      default: s = 4'b1111;
    endcase
    return s;
  endfunction

  function automatic logic [31:0] zext(input logic [WIDTH-1:0] v);
    logic [31:0] r;
    r = '0;
    r[WIDTH-1:0] = v;
    return r;
  endfunction

  // Data-phase bookkeeping captured in the address phase.
  logic             dp_valid_q, dp_valid_d;
  logic             dp_write_q, dp_write_d;
  logic [3:0]       dp_off_q,   dp_off_d;
  logic [3:0]       dp_strb_q,  dp_strb_d;

  logic [WIDTH-1:0] data_out_q, data_out_d;
  logic [WIDTH-1:0] dir_q,      dir_d;
  logic [WIDTH-1:0] int_en_q,   int_en_d;
  logic [WIDTH-1:0] int_type_q, int_type_d;
  logic [WIDTH-1:0] int_pol_q,  int_pol_d;
  logic [WIDTH-1:0] edge_st_q,  edge_st_d;
  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] sync_d [SYNC_STAGES];
  logic [WIDTH-1:0] prev_q,     prev_d;
  logic             irq_q,      irq_d;

  logic             wr_en;
  logic [WIDTH-1:0] wmask, wbits, w1c;
  logic [WIDTH-1:0] sync_now, rise, fall, edge_set, int_status;

  logic unused_bits;
  assign unused_bits = ^{HPROT, HADDR[31:6], HWDATA, dp_strb_q, HTRANS[0]};

  // Address phase: only selected NONSEQ/SEQ transfers with HREADY open a
  // data phase; anything else leaves the next cycle idle.
  always_comb begin
    dp_valid_d = HSEL & HREADY & HTRANS[1];
    dp_write_d = HWRITE;
    dp_off_d   = HADDR[5:2];
    dp_strb_d  = byte_strobes(HSIZE, HADDR[1:0]);
  end

  always_comb begin
    for (int i = 0; i < WIDTH; i++) begin
      wmask[i] = dp_strb_q[i/8];
    end
  end

  assign wr_en = dp_valid_q & dp_write_q;
  assign wbits = HWDATA[WIDTH-1:0] & wmask;

  // Input synchronizer followed by one "prev" flop for edge detection.
  always_comb begin
    sync_d[0] = GPIO_IN;
    for (int i = 1; i < SYNC_STAGES; i++) begin
      sync_d[i] = sync_q[i-1];
    end
  end

  assign sync_now = sync_q[SYNC_STAGES-1];
  assign prev_d   = sync_now;
  assign rise     = sync_now & ~prev_q;
  assign fall     = ~sync_now & prev_q;
  assign edge_set = int_type_q & ((int_pol_q & rise) | (~int_pol_q & fall));

  // Edge bits are stored; level bits are the live comparison of the pin
  // against its polarity.
  assign int_status = edge_st_q | (~int_type_q & ~(sync_now ^ int_pol_q));

  // Register writes commit at the edge closing the data phase.
  always_comb begin
    data_out_d = data_out_q;
    dir_d      = dir_q;
    int_en_d   = int_en_q;
    int_type_d = int_type_q;
    int_pol_d  = int_pol_q;
    w1c        = '0;
    if (wr_en) begin
      case (dp_off_q)
        OFF_DATA_OUT:   data_out_d = (data_out_q & ~wmask) | wbits;
        OFF_OUT_SET:    data_out_d = data_out_q | wbits;
        OFF_OUT_CLR:    data_out_d = data_out_q & ~wbits;
        OFF_DIR:        dir_d      = (dir_q & ~wmask) | wbits;
        OFF_INT_EN:     int_en_d   = (int_en_q & ~wmask) | wbits;
        OFF_INT_TYPE:   int_type_d = (int_type_q & ~wmask) | wbits;
        OFF_INT_POL:    int_pol_d  = (int_pol_q & ~wmask) | wbits;
        OFF_INT_STATUS: w1c        = wbits;
        default:        ;
      endcase
    end
  end

  // A new edge beats a simultaneous W1C; masking with the next INT_TYPE
  // drops stored edge status for pins being switched to level mode.
  assign edge_st_d = ((edge_st_q & ~w1c) | edge_set) & int_type_d;
  assign irq_d     = |(int_status & int_en_q);

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      dp_valid_q <= 1'b0;
      dp_write_q <= 1'b0;
      dp_off_q   <= '0;
      dp_strb_q  <= '0;
      data_out_q <= RESET_OUT;
      dir_q      <= '0;
      int_en_q   <= '0;
      int_type_q <= '0;
      int_pol_q  <= '0;
      edge_st_q  <= '0;
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= '0;
      end
      prev_q     <= '0;
      irq_q      <= 1'b0;
    end else begin
      dp_valid_q <= dp_valid_d;
      dp_write_q <= dp_write_d;
      dp_off_q   <= dp_off_d;
      dp_strb_q  <= dp_strb_d;
      data_out_q <= data_out_d;
      dir_q      <= dir_d;
      int_en_q   <= int_en_d;
      int_type_q <= int_type_d;
      int_pol_q  <= int_pol_d;
      edge_st_q  <= edge_st_d;
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_d[i];
      end
      prev_q     <= prev_d;
      irq_q      <= irq_d;
    end
  end

  // Read data is a combinational view of the registers during a read data
  // phase, so a write committed on the preceding edge is already visible.
  always_comb begin
    HRDATA = '0;
    if (dp_valid_q && !dp_write_q) begin
      case (dp_off_q)
        OFF_DATA_IN:    HRDATA = zext(sync_now);
        OFF_DATA_OUT:   HRDATA = zext(data_out_q);
        OFF_DIR:        HRDATA = zext(dir_q);
        OFF_INT_EN:     HRDATA = zext(int_en_q);
        OFF_INT_TYPE:   HRDATA = zext(int_type_q);
        OFF_INT_POL:    HRDATA = zext(int_pol_q);
        OFF_INT_STATUS: HRDATA = zext(int_status);
        default:        HRDATA = '0;
      endcase
    end
  end

  assign HREADYOUT = 1'b1;
  assign HRESP     = 1'b0;
  assign GPIO_OUT  = data_out_q;
  assign GPIO_OE   = dir_q;
  assign IRQ       = irq_q;

endmodule

// File: tb/tb_ahb_gpio.sv
// tb_ahb_gpio: scoreboard bench for ahb_gpio (WIDTH=16, SYNC_STAGES=2,
// RESET_OUT=16'h00A5). A reference model tracks the register file and pin
// history; read responses go through a queue that a negedge monitor drains.
module tb_ahb_gpio;
  localparam int             W  = 16;
  localparam int             S  = 2;
  localparam logic [W-1:0]   RO = 16'h00A5;

  logic          HCLK = 1'b0;
  logic          HRESETn = 1'b0;
  logic          HSEL = 1'b0;
  logic [31:0]   HADDR = '0;
  logic [1:0]    HTRANS = '0;
  logic [2:0]    HSIZE = '0;
  logic [3:0]    HPROT = '0;
  logic          HWRITE = 1'b0;
  logic          HREADY = 1'b1;
  logic [31:0]   HWDATA = '0;
  logic          HREADYOUT;
  logic [31:0]   HRDATA;
  logic          HRESP;
  logic [W-1:0]  GPIO_IN = '0;
  logic [W-1:0]  GPIO_OUT;
  logic [W-1:0]  GPIO_OE;
  logic          IRQ;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 HCLK = ~HCLK;

  ahb_gpio #(.WIDTH(W), .SYNC_STAGES(S), .RESET_OUT(RO)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(HSEL), .HADDR(HADDR),
    .HTRANS(HTRANS), .HSIZE(HSIZE), .HPROT(HPROT), .HWRITE(HWRITE),
    .HREADY(HREADY), .HWDATA(HWDATA), .HREADYOUT(HREADYOUT),
    .HRDATA(HRDATA), .HRESP(HRESP), .GPIO_IN(GPIO_IN),
    .GPIO_OUT(GPIO_OUT), .GPIO_OE(GPIO_OE), .IRQ(IRQ)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [W-1:0]  m_out, m_dir, m_en, m_type, m_pol, m_edge;
  logic          m_irq;
  logic [W-1:0]  hist[$];       // hist[j] = pin sample taken j edges ago
  logic          pend_v;
  logic [3:0]    pend_off;
  logic [3:0]    pend_strb;
  logic [31:0]   exp_q[$];

  function automatic logic [3:0] strobes(input logic [2:0] size, input logic [1:0] a);
    int nbytes, start;
    logic [3:0] s;
    nbytes = (size >= 3'd2) ? 4 : (1 << size);
    start  = int'(a) - (int'(a) % nbytes);
    s = '0;
    for (int b = 0; b < 4; b++) s[b] = (b >= start) && (b < start + nbytes);
    return s;
  endfunction

  function automatic logic [W-1:0] status_of(input logic [W-1:0] pins);
    logic [W-1:0] st;
    for (int i = 0; i < W; i++)
      st[i] = m_type[i] ? m_edge[i] : (pins[i] == m_pol[i]);
    return st;
  endfunction

  function automatic logic [31:0] read_val(input logic [3:0] off);
    case (off)
      4'h0: return 32'(hist[S-1]);
      4'h1: return 32'(m_out);
      4'h4: return 32'(m_dir);
      4'h5: return 32'(m_en);
      4'h6: return 32'(m_type);
      4'h7: return 32'(m_pol);
      4'h8: return 32'(status_of(hist[S-1]));
      default: return 32'h0;
    endcase
  endfunction

  task automatic model_reset();
    m_out = RO; m_dir = '0; m_en = '0; m_type = '0; m_pol = '0; m_edge = '0;
    m_irq = 1'b0; pend_v = 1'b0; pend_off = '0; pend_strb = '0;
    hist.delete();
    for (int j = 0; j <= S; j++) hist.push_back('0);
    exp_q.delete();
  endtask

  task automatic model_step();
    logic [W-1:0] sync_o, prev_o, setb, w1c, dw, mw;
    logic [31:0]  m32;
    logic         irq_n;
    sync_o = hist[S-1];
    prev_o = hist[S];
    irq_n  = |(status_of(sync_o) & m_en);
    for (int i = 0; i < W; i++) begin
      if (m_pol[i]) setb[i] = m_type[i] && sync_o[i] && !prev_o[i];
      else          setb[i] = m_type[i] && !sync_o[i] && prev_o[i];
    end
    w1c = '0;
    if (pend_v) begin
      m32 = {{8{pend_strb[3]}}, {8{pend_strb[2]}}, {8{pend_strb[1]}}, {8{pend_strb[0]}}};
      mw  = m32[W-1:0];
      dw  = HWDATA[W-1:0] & mw;
      case (pend_off)
        4'h1: m_out  = (m_out & ~mw) | dw;
        4'h2: m_out  = m_out | dw;
        4'h3: m_out  = m_out & ~dw;
        4'h4: m_dir  = (m_dir & ~mw) | dw;
        4'h5: m_en   = (m_en & ~mw) | dw;
        4'h6: m_type = (m_type & ~mw) | dw;
        4'h7: m_pol  = (m_pol & ~mw) | dw;
        4'h8: w1c    = dw;
        default: ;
      endcase
    end
    m_edge = ((m_edge & ~w1c) | setb) & m_type;
    m_irq  = irq_n;
    hist.push_front(GPIO_IN);
    void'(hist.pop_back());
    pend_v = 1'b0;
    if (HSEL && HREADY && HTRANS[1]) begin
      if (HWRITE) begin
        pend_v    = 1'b1;
        pend_off  = HADDR[5:2];
        pend_strb = strobes(HSIZE, HADDR[1:0]);
      end else begin
        exp_q.push_back(read_val(HADDR[5:2]));
      end
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge HCLK or negedge HRESETn);
      if (!HRESETn) model_reset();
      else          model_step();
    end
  end

  // ---------------- monitor ----------------
  initial begin
    forever begin
      @(negedge HCLK);
      chk("gpio_out", 32'(GPIO_OUT), 32'(m_out));
      chk("gpio_oe", 32'(GPIO_OE), 32'(m_dir));
      chk("irq", 32'(IRQ), 32'(m_irq));
      chk("hreadyout", 32'(HREADYOUT), 32'h1);
      chk("hresp", 32'(HRESP), 32'h0);
      if (exp_q.size() > 0) chk("hrdata", HRDATA, exp_q.pop_front());
      else                  chk("hrdata_idle", HRDATA, 32'h0);
    end
  end

  // ---------------- stimulus ----------------
  task automatic nxt();
    @(negedge HCLK);
    #1;
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) nxt();
  endtask

  task automatic xfer(input logic sel, input logic [1:0] tr, input logic wr,
                      input logic [31:0] a, input logic [2:0] sz, input logic [31:0] wd);
    HSEL = sel; HTRANS = tr; HWRITE = wr; HADDR = a; HSIZE = sz;
    HPROT = 4'($urandom);
    nxt();
    if (wr) HWDATA = wd;
    HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [2:0] sz);
    xfer(1'b1, 2'b10, 1'b1, a, sz, d);
  endtask

  task automatic rdchk(input logic [31:0] a, input logic [31:0] exp, input string name);
    xfer(1'b1, 2'b10, 1'b0, a, 3'd2, 32'h0);
    chk(name, HRDATA, exp);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int kind, off, sz, lane;
    HRESETn = 1'b0;
    wait_cyc(3);
    chk("rst_gpio_out", 32'(GPIO_OUT), 32'h00A5);
    chk("rst_gpio_oe", 32'(GPIO_OE), 32'h0);
    chk("rst_irq", 32'(IRQ), 32'h0);
    chk("rst_hrdata", HRDATA, 32'h0);
    HRESETn = 1'b1;
    wait_cyc(2);
    rdchk(32'h10, 32'h0, "rd_dir_reset");
    rdchk(32'h3C, 32'h0, "rd_unmapped");
    wait_cyc(1);

    // output register: write, atomic set, atomic clear, byte lane write
    wr(32'h04, 32'h0000_000F, 3'd2);
    wr(32'h08, 32'h0000_00F0, 3'd2);
    wr(32'h0C, 32'h0000_0003, 3'd2);
    rdchk(32'h04, 32'h0000_00FC, "rd_out_fc");
    wait_cyc(1);
    chk("out_fc", 32'(GPIO_OUT), 32'h00FC);
    wr(32'h05, 32'h0000_5500, 3'd0);
    wait_cyc(1);
    chk("out_byte1", 32'(GPIO_OUT), 32'h55FC);
    wr(32'h10, 32'h0000_A00A, 3'd2);
    wait_cyc(1);
    chk("oe_dir", 32'(GPIO_OE), 32'hA00A);

    // rising-edge interrupt on pin 2
    GPIO_IN = 16'hFFFB;
    wait_cyc(4);
    wr(32'h18, 32'h4, 3'd2);
    wr(32'h1C, 32'h4, 3'd2);
    wr(32'h14, 32'h4, 3'd2);
    wait_cyc(2);
    chk("irq_idle", 32'(IRQ), 32'h0);
    GPIO_IN[2] = 1'b1;
    wait_cyc(S + 1);
    chk("irq_not_yet", 32'(IRQ), 32'h0);
    nxt();
    chk("irq_edge_latency", 32'(IRQ), 32'h1);
    rdchk(32'h20, 32'h4, "rd_status_edge");
    wr(32'h20, 32'h4, 3'd2);
    nxt();
    chk("irq_w1c_hold", 32'(IRQ), 32'h1);
    nxt();
    chk("irq_w1c_low", 32'(IRQ), 32'h0);

    // new edge in the same cycle as W1C of that bit
    GPIO_IN[2] = 1'b0; wait_cyc(4);
    GPIO_IN[2] = 1'b1; wait_cyc(5);
    chk("irq_rearmed", 32'(IRQ), 32'h1);
    GPIO_IN[2] = 1'b0; wait_cyc(4);
    GPIO_IN[2] = 1'b1;
    repeat (S - 1) nxt();
    wr(32'h20, 32'h4, 3'd2);
    nxt(); nxt();
    chk("irq_set_wins", 32'(IRQ), 32'h1);
    rdchk(32'h20, 32'h4, "rd_set_wins");

    // level-low interrupt on pin 0
    wr(32'h14, 32'h1, 3'd2);
    wait_cyc(2);
    chk("irq_lvl_idle", 32'(IRQ), 32'h0);
    GPIO_IN[0] = 1'b0;
    wait_cyc(3);
    chk("irq_lvl_on", 32'(IRQ), 32'h1);
    rdchk(32'h20, 32'h5, "rd_status_lvl");
    wr(32'h20, 32'h1, 3'd2);
    wait_cyc(2);
    chk("irq_lvl_w1c", 32'(IRQ), 32'h1);
    rdchk(32'h20, 32'h5, "rd_status_lvl_w1c");
    GPIO_IN[0] = 1'b1;
    wait_cyc(3);
    chk("irq_lvl_off", 32'(IRQ), 32'h0);

    // switching edge->level discards stored edge status
    wr(32'h18, 32'h0, 3'd2);
    wr(32'h1C, 32'h0, 3'd2);
    wr(32'h18, 32'h4, 3'd2);
    rdchk(32'h20, 32'h0, "rd_edge_discard");
    wait_cyc(1);

    // randomized traffic against the model
    for (int it = 0; it < 400; it++) begin
      if ($urandom_range(0, 9) < 2) GPIO_IN = W'($urandom);
      kind = int'($urandom_range(0, 9));
      off  = int'($urandom_range(0, 15));
      sz   = int'($urandom_range(0, 2));
      lane = (sz == 0) ? int'($urandom_range(0, 3)) : (sz == 1) ? 2 * int'($urandom_range(0, 1)) : 0;
      if (kind <= 3)
        wr({26'd0, 4'(off), 2'd0} | 32'(lane), $urandom, 3'(sz));
      else if (kind <= 6)
        xfer(1'b1, 2'b10, 1'b0, {26'd0, 4'(off), 2'd0}, 3'd2, 32'h0);
      else if (kind == 7)
        xfer(1'b0, 2'b10, 1'($urandom), {26'd0, 4'(off), 2'd0}, 3'd2, $urandom);
      else if (kind == 8)
        xfer(1'b1, 2'b01, 1'($urandom), {26'd0, 4'(off), 2'd0}, 3'd2, $urandom);
      else
        nxt();
    end
    wait_cyc(2);

    // reset during a write data phase
    wr(32'h04, 32'h0000_1234, 3'd2);
    HRESETn = 1'b0;
    #1;
    chk("rst_mid_out", 32'(GPIO_OUT), 32'h00A5);
    nxt(); nxt();
    HRESETn = 1'b1;
    wait_cyc(3);
    chk("rst_no_commit", 32'(GPIO_OUT), 32'h00A5);
    chk("rst_oe", 32'(GPIO_OE), 32'h0);
    chk("queue_drained", 32'(exp_q.size()), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
